// File: rtl/tt_um_aditya_patra_ranger.sv
// -----------------------------------------------------------------------------
// tt_um_aditya_patra_ranger
//
// Round-robin scanner for three ultrasonic ranging sensors. Each sensor is
// triggered in turn (0,1,2,0,...). Its echo pulse width is measured and
// turned into an "obstacle close" flag for that direction, which the
// warning state machine downstream consumes.
//
// Ports
//   clk      : single clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : design enable; low returns the scanner to IDLE with flags cleared
//   ui_in    : [2:0] raw echo inputs for sensors 0..2, [7:3] unused
//   uo_out   : [2:0] close flags, [3] busy, [5:4] active sensor index, [7:6] 0
//   uio_in   : unused
//   uio_out  : [2:0] trigger outputs for sensors 0..2, [7:3] 0
//   uio_oe   : constant 8'b00000111 (trigger pins driven)
//
// Build option
//   RANGER_HYST_EN : when defined, a flag changes only after two consecutive
//                    results that disagree with it. Otherwise every result is
//                    written straight to the flag.
// -----------------------------------------------------------------------------
module tt_um_aditya_patra_ranger #(
   parameter int TRIG_CYCLES  = 10,
   parameter int RISE_TIMEOUT = 5000,
   parameter int ECHO_MAX     = 30000,
   parameter int THRESH       = 5800,
   parameter int GAP_CYCLES   = 60000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      GAP       = 3'd4
   } state_t;

   // The counter restarts at 0 on state entry, so "held N cycles" means the
   // exit fires while the counter shows N-1.
   localparam logic [15:0] TRIG_LAST = 16'(TRIG_CYCLES - 1);
   localparam logic [15:0] RISE_LAST = 16'(RISE_TIMEOUT - 1);
   localparam logic [15:0] ECHO_LAST = 16'(ECHO_MAX - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
   localparam logic [16:0] THRESH_W  = 17'(THRESH);

   state_t      state;
   logic [1:0]  idx;
   logic [15:0] cnt;
   logic [2:0]  flags;
   logic [2:0]  trig;
   logic [2:0]  echo_s1;
   logic [2:0]  echo_s2;
   logic        echo_cur;
   logic        res_valid;
   logic        res_close;
   logic [16:0] width;
   logic [2:0]  flags_nx;
   logic        busy;
`ifdef RANGER_HYST_EN
   logic [2:0]  pend;
   logic [2:0]  pend_nx;
`endif

   // Pins this block never looks at.
   logic unused_ok;
   assign unused_ok = &{1'b0, uio_in, ui_in[7:3]};

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] i);
      logic [2:0] r;
      r = 3'b000;
      case (i)
         2'd0:    r = 3'b001;
         2'd1:    r = 3'b010;
         2'd2:    r = 3'b100;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   // Two-flop synchronizer on every echo input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_s1 <= 3'b000;
         echo_s2 <= 3'b000;
      end else begin
         echo_s1 <= ui_in[2:0];
         echo_s2 <= echo_s1;
      end
   end

   always_comb begin
      echo_cur = 1'b0;
      case (idx)
         2'd0:    echo_cur = echo_s2[0];
         2'd1:    echo_cur = echo_s2[1];
         2'd2:    echo_cur = echo_s2[2];
         default: echo_cur = 1'b0;
      endcase
   end

   // The synchronized echo was already high for the one WAIT_RISE cycle
   // that detected the rise, so the pulse width is the counter plus one.
   assign width = {1'b0, cnt} + 17'd1;

   // Measurement result, valid on the exit cycle of WAIT_RISE or MEASURE.
   always_comb begin
      res_valid = 1'b0;
      res_close = 1'b0;
      case (state)
         WAIT_RISE: begin
            if (!echo_cur && cnt == RISE_LAST) res_valid = 1'b1;
         end
         MEASURE: begin
            if (!echo_cur) begin
               res_valid = 1'b1;
               res_close = (width < THRESH_W);
            end else if (cnt == ECHO_LAST) begin
               res_valid = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Flag update for the active sensor only.
   always_comb begin
      flags_nx = flags;
`ifdef RANGER_HYST_EN
      pend_nx  = pend;
      if (res_valid) begin
         if (res_close == flags[idx]) begin
            pend_nx[idx] = 1'b0;
         end else if (pend[idx]) begin
            flags_nx[idx] = res_close;
            pend_nx[idx]  = 1'b0;
         end else begin
            pend_nx[idx] = 1'b1;
         end
      end
`else
      if (res_valid) flags_nx[idx] = res_close;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= 2'd0;
         cnt   <= 16'd0;
         flags <= 3'b000;
         trig  <= 3'b000;
`ifdef RANGER_HYST_EN
         pend  <= 3'b000;
`endif
      end else if (!ena) begin
         state <= IDLE;
         idx   <= 2'd0;
         cnt   <= 16'd0;
         flags <= 3'b000;
         trig  <= 3'b000;
`ifdef RANGER_HYST_EN
         pend  <= 3'b000;
`endif
      end else begin
         cnt   <= sat_inc(cnt);
         flags <= flags_nx;
`ifdef RANGER_HYST_EN
         pend  <= pend_nx;
`endif
         case (state)
            IDLE: begin
               state <= TRIG;
               cnt   <= 16'd0;
               trig  <= onehot(idx);
            end
            TRIG: begin
               if (cnt == TRIG_LAST) begin
                  state <= WAIT_RISE;
                  cnt   <= 16'd0;
                  trig  <= 3'b000;
               end
            end
            WAIT_RISE: begin
               // Rise is checked before timeout so an echo already high on
               // entry is taken as a rise on the first cycle.
               if (echo_cur) begin
                  state <= MEASURE;
                  cnt   <= 16'd0;
               end else if (cnt == RISE_LAST) begin
                  state <= GAP;
                  cnt   <= 16'd0;
               end
            end
            MEASURE: begin
               if (!echo_cur || cnt == ECHO_LAST) begin
                  state <= GAP;
                  cnt   <= 16'd0;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  state <= TRIG;
                  cnt   <= 16'd0;
                  idx   <= next_idx(idx);
                  trig  <= onehot(next_idx(idx));
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 16'd0;
               trig  <= 3'b000;
            end
         endcase
      end
   end

   assign busy    = (state == TRIG) || (state == WAIT_RISE) || (state == MEASURE);
   assign uo_out  = {2'b00, idx, busy, flags};
   assign uio_out = {5'b00000, trig};
   assign uio_oe  = 8'b00000111;

endmodule

// File: doc/tt_um_aditya_patra_ranger.md
TT_UM_ADITYA_PATRA_RANGER -- requirements
Module: tt_um_aditya_patra_ranger

Scans three ultrasonic ranging sensors and produces the per-direction "obstacle close" flags that the warning state machine consumes.

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TRIG_CYCLES, 10: trigger pulse width in clk cycles (10 us at 1 MHz).
- RISE_TIMEOUT, 5000: max cycles from trigger end to echo rise.
- ECHO_MAX, 30000: max echo width in cycles; reaching it means no echo.
- THRESH, 5800: echo width below this is "close" (about 1 m).
- GAP_CYCLES, 60000: settle gap after each measurement.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1: single clock; all state is on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- ena, in, 1: design enable.
- ui_in, in, 8: [2:0] echo inputs for sensors 0..2; [7:3] unused.
- uo_out, out, 8: [2:0] close flags; [3] busy; [5:4] active sensor index; [7:6] 0.
- uio_in, in, 8: unused.
- uio_out, out, 8: [2:0] trigger outputs for sensors 0..2; [7:3] 0.
- uio_oe, out, 8: constant 8'b00000111.

Function
REQ-003 Each echo input passes through a 2-flop synchronizer; all echo decisions use the synchronized value only.
REQ-004 FSM states and transitions:
- IDLE -> TRIG, when ena=1.
- TRIG -> WAIT_RISE, after the trigger is held for TRIG_CYCLES.
- WAIT_RISE -> MEASURE, on echo=1; -> GAP on timeout.
- MEASURE -> GAP, on echo=0 or when the count reaches ECHO_MAX.
- GAP -> TRIG, after GAP_CYCLES, with the index advanced.
REQ-005 TRIG asserts only uio_out[idx] high, for exactly TRIG_CYCLES cycles; all other trigger bits are low at all times.
REQ-006 The index sequence is 0,1,2,0,...; it wraps from 2 to 0 and never takes the value 3.
REQ-007 There is one 16-bit cycle counter: cleared on every state entry, incremented once per cycle, and saturating at 16'hFFFF.
REQ-008 WAIT_RISE lasting RISE_TIMEOUT cycles with no rise counts as a "far" result for that sensor.
REQ-009 MEASURE result: width < THRESH is "close"; width >= THRESH, or reaching ECHO_MAX, is "far".
REQ-010 The result is applied to flag[idx] on the cycle of the MEASURE/WAIT_RISE exit; the other flags are unchanged.
REQ-011 Latency: a flag updates 1 cycle after the synchronized echo falls, which is 3 cycles after the raw echo falls.
REQ-012 An echo already high on entry to WAIT_RISE is treated as a rise on the first WAIT_RISE cycle.
REQ-013 busy (uo_out[3]) = 1 in TRIG, WAIT_RISE and MEASURE; 0 in IDLE and GAP.
REQ-014 ena=0 forces, on the next clock edge: state IDLE, index 0, triggers 0, flags 0, counter 0.

Reset
REQ-015 While rst_n=0, asynchronously: state IDLE, index 0, counter 0, synchronizers 0, flags 0, uo_out=0, uio_out=0.
REQ-016 Reset applied mid-measurement aborts the measurement without a flag update; after release the scan restarts at sensor 0.

Configuration
REQ-017 Macro RANGER_HYST_EN selects flag hysteresis.
- Defined: a flag sets only after 2 consecutive "close" results for that sensor and clears only after 2 consecutive "far" results; one pending bit per sensor, reset to 0.
- Not defined: every result is written to the flag directly, per REQ-010.

Verification
REQ-018 The bench shall cover at least these scenarios:
- Release reset with ena=1 and all echoes low -> uio_out[0] high for exactly 10 cycles; after 5000 cycles, sensor 0 is "far" and the index reaches 1 after GAP_CYCLES more.
- Echo0 high for 3000 cycles -> uo_out[0]=1 three cycles after the raw fall; uo_out[2:1] unchanged.
- Echo1 high for 5800 cycles -> uo_out[1]=0 (boundary); 5799 cycles -> uo_out[1]=1.
- Echo2 held high -> MEASURE exits at 30000 cycles, flag2=0, and the index wraps to 0.
- Echo0 width 1000 with rst_n pulsed low mid-MEASURE -> all outputs 0 immediately, no flag set, rescan starts at sensor 0.
- RANGER_HYST_EN defined: sensor 0 close, far, close, close -> uo_out[0] goes 0, 0, 0, 1 after each respective scan.
